click_decoder: RTL

- Sits directly downstream of the button debouncer. Consumes its single-cycle press pulse.
- Groups pulses that arrive within a programmable inactivity window into one click event (single / double / ... up to MAX_CLICKS).
- Presents each event to the control logic on a valid/ready output register.

---
 rtl/click_decoder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/click_decoder.sv
// Groups debounced press pulses that fall inside an inactivity window into a single click event.
// Optional CLICK_DECODER_STATS_EN adds accepted-event and dropped-event counters.
module click_decoder #(
   parameter int WINDOW_CYCLES = 20,
   parameter int MAX_CLICKS    = 3,
   parameter int TIMER_W       = $clog2(WINDOW_CYCLES),
   parameter int CLICK_W       = $clog2(MAX_CLICKS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               press_pulse,
   input  logic               event_ready,
   output logic               event_valid,
   output logic [CLICK_W-1:0] event_clicks,
   output logic               overrun
`ifdef CLICK_DECODER_STATS_EN
   ,
   output logic [7:0]         event_total,
   output logic [7:0]         drop_total
`endif
);

   typedef enum logic {IDLE, COUNTING} state_t;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
   localparam logic [CLICK_W-1:0] COUNT_LAST = CLICK_W'(MAX_CLICKS - 1);
   localparam logic [CLICK_W-1:0] COUNT_MAX  = CLICK_W'(MAX_CLICKS);

   state_t             state, state_nxt;
   logic [CLICK_W-1:0] count, count_nxt, emit_clicks;
   logic [TIMER_W-1:0] timer, timer_nxt;
   logic               emit, accept, load, drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         timer <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         timer <= timer_nxt;
      end
   end

   // A press always beats window expiry: it is counted and restarts the timer.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      timer_nxt   = timer;
      emit        = 1'b0;
      emit_clicks = count;
      case (state)
         IDLE: begin
            if (press_pulse) begin
               count_nxt = CLICK_W'(1);
               timer_nxt = '0;
               state_nxt = COUNTING;
            end
         end
         COUNTING: begin
            if (press_pulse) begin
               timer_nxt = '0;
               if (count == COUNT_LAST) begin
                  emit        = 1'b1;
                  emit_clicks = COUNT_MAX;
                  count_nxt   = '0;
                  state_nxt   = IDLE;
               end else begin
                  count_nxt = count + CLICK_W'(1);
               end
            end else if (timer == TIMER_LAST) begin
               emit        = 1'b1;
               emit_clicks = count;
               count_nxt   = '0;
               timer_nxt   = '0;
               state_nxt   = IDLE;
            end else begin
               timer_nxt = timer + TIMER_W'(1);
            end
         end
      endcase
   end

   // The output register never back-pressures the counter; a blocked emit is dropped.
   always_comb begin
      accept = event_valid & event_ready;
      load   = emit & (~event_valid | event_ready);
      drop   = emit & event_valid & ~event_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         event_valid  <= 1'b0;
         event_clicks <= '0;
         overrun      <= 1'b0;
      end else begin
         overrun <= drop;
         if (load) begin
            event_valid  <= 1'b1;
            event_clicks <= emit_clicks;
         end else if (accept) begin
            event_valid <= 1'b0;
         end
      end
   end

`ifdef CLICK_DECODER_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         event_total <= '0;
         drop_total  <= '0;
      end else begin
         if (accept) event_total <= event_total + 8'd1;
         if (drop && drop_total != 8'hFF) drop_total <= drop_total + 8'd1;
      end
   end
`endif

endmodule
